// File: rtl/bus_source_arbiter_pkg.sv
// Shared constants for the bus source arbiter: mux source codes and FSM states.
package bus_source_arbiter_pkg;

    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_R3     = 3;
    localparam int SRC_R4     = 4;
    localparam int SRC_R5     = 5;
    localparam int SRC_R6     = 6;
    localparam int SRC_R7     = 7;
    localparam int SRC_R8     = 8;
    localparam int SRC_R9     = 9;
    localparam int SRC_R10    = 10;
    localparam int SRC_R11    = 11;
    localparam int SRC_R12    = 12;
    localparam int SRC_R13    = 13;
    localparam int SRC_R14    = 14;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_CSIGN  = 23;
    // The mux drives zero for this code, so it doubles as the parked select.
    localparam int SRC_IDLE   = 31;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bus_source_arbiter_if.sv
// Requester/bus-select bundle between the control units and the source arbiter.
interface bus_source_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 5,
    parameter int LEN_W   = 3
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*SEL_W-1:0] req_src;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [SEL_W-1:0]         bus_sel;
    logic                     bus_valid;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic [NUM_REQ-1:0]       err;

    modport master (
        output req, req_src, req_len,
        input  bus_sel, bus_valid, grant, done, err
    );

    modport slave (
        input  req, req_src, req_len,
        output bus_sel, bus_valid, grant, done, err
    );
endinterface

// File: rtl/bus_source_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate req by rr_ptr, find the lowest set bit,
// rotate the index back. Works for any requester count, not just powers of two.
module bus_source_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   win,
    output logic               win_valid
);

    function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;

    always_comb begin
        rot       = '0;
        off       = '0;
        win_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[add_mod(rr_ptr, i)];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off       = IDX_W'(i);
                win_valid = 1'b1;
            end
        end
        win = add_mod(rr_ptr, int'(off));
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin owner of the internal bus source mux select; grants one requester
// for len+1 cycles and pulses done on the last cycle, or err for an illegal code.
//
// state | meaning
// IDLE  | bus parked on IDLE_SEL, arbitrating every edge
// XFER  | bus_sel/grant frozen for the owner, count runs down to 0
module bus_source_arbiter
    import bus_source_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = 5,
    parameter int MAX_SRC  = SRC_CSIGN,
    parameter int IDLE_SEL = SRC_IDLE,
    parameter int LEN_W    = 3
) (
    input logic                 clock,
    input logic                 clear,
    bus_source_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state, state_nxt;
    logic [LEN_W-1:0]   count, count_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [SEL_W-1:0]   sel_q, sel_nxt;
    logic               valid_q, valid_nxt;
    logic [NUM_REQ-1:0] grant_q, grant_nxt;
    logic [NUM_REQ-1:0] done_q, done_nxt;
    logic [NUM_REQ-1:0] err_q, err_nxt;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [SEL_W-1:0]   pick_src;
    logic [LEN_W-1:0]   pick_len;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               src_ok;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    bus_source_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req       (bus.req),
        .rr_ptr    (rr_ptr),
        .win       (pick_idx),
        .win_valid (pick_valid)
    );

    assign pick_src    = bus.req_src[pick_idx*SEL_W +: SEL_W];
    assign pick_len    = bus.req_len[pick_idx*LEN_W +: LEN_W];
    assign pick_onehot = NUM_REQ'(1) << pick_idx;
    assign src_ok      = (pick_src <= SEL_W'(MAX_SRC));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid && src_ok) state_nxt = XFER;
            XFER:    if (count == '0)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is computed here one cycle early and registered below.
    always_comb begin
        count_nxt  = count;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        sel_nxt    = SEL_W'(IDLE_SEL);
        valid_nxt  = 1'b0;
        grant_nxt  = '0;
        done_nxt   = '0;
        err_nxt    = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    if (src_ok) begin
                        owner_nxt = pick_idx;
                        count_nxt = pick_len;
                        sel_nxt   = pick_src;
                        valid_nxt = 1'b1;
                        grant_nxt = pick_onehot;
                        done_nxt  = (pick_len == '0) ? pick_onehot : '0;
                    end else begin
                        err_nxt    = pick_onehot;
                        rr_ptr_nxt = next_idx(pick_idx);
                    end
                end
            end
            XFER: begin
                if (count != '0) begin
                    count_nxt = count - 1'b1;
                    sel_nxt   = sel_q;
                    valid_nxt = 1'b1;
                    grant_nxt = grant_q;
                    done_nxt  = (count == LEN_W'(1)) ? grant_q : '0;
                end else begin
                    rr_ptr_nxt = next_idx(owner);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count   <= '0;
            rr_ptr  <= '0;
            owner   <= '0;
            sel_q   <= SEL_W'(IDLE_SEL);
            valid_q <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            count   <= count_nxt;
            rr_ptr  <= rr_ptr_nxt;
            owner   <= owner_nxt;
            sel_q   <= sel_nxt;
            valid_q <= valid_nxt;
            grant_q <= grant_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

    assign bus.bus_sel   = sel_q;
    assign bus.bus_valid = valid_q;
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Shares the 32-bit internal bus source multiplexer among several requesters: control FSM, interrupt/IO unit, debug port, and so on.
- Each requester asks for the bus with a 5-bit source code and a transfer length.
- The block picks one requester by round-robin, drives the mux select for the granted number of cycles, and signals completion.
- Sits between the control units and the bus source multiplexer. It is the only driver of the mux select.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEL_W, 5, width of the mux source-select code.
- MAX_SRC, 23, highest legal source code (0-15 GPRs, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C_sign_extended).
- IDLE_SEL, 31, select driven when no transfer is active; the mux outputs 0 for this code.
- LEN_W, 3, width of the length field; the transfer lasts len+1 cycles (1..8).

Ports:
- clock, in, 1: rising-edge clock.
- clear, in, 1: asynchronous, active-low reset.
- req, in, NUM_REQ: per-requester request level. Held high until done or err is seen.
- req_src, in, NUM_REQ*SEL_W: packed source codes; requester i uses bits [i*SEL_W +: SEL_W].
- req_len, in, NUM_REQ*LEN_W: packed lengths, same packing as req_src.
- bus_sel, out, SEL_W: registered select to the bus mux.
- bus_valid, out, 1: high while bus_sel carries a granted source.
- grant, out, NUM_REQ: one-hot owner of the bus. Zero when idle.
- done, out, NUM_REQ: one-cycle pulse on the last transfer cycle of the owner.
- err, out, NUM_REQ: one-cycle pulse when the request carried an illegal source code.

Behaviour:
- Reset values:
  - bus_sel = IDLE_SEL; all other outputs 0.
  - rr_ptr = 0, count = 0, state = IDLE.
  - clear takes effect immediately at any time, including mid-transfer; the aborted requester gets no done.
- States: IDLE, XFER. All outputs are registered.
- Arbitration in IDLE:
  - Search order starts at rr_ptr and wraps modulo NUM_REQ; the first requester with req high wins (index w).
  - The winning requester's req_src and req_len are latched in the same edge.
- Legal source (req_src[w] <= MAX_SRC) at clock edge k:
  - From cycle k+1: state = XFER, grant = onehot(w), bus_sel = src, bus_valid = 1, count = len.
- Illegal source:
  - err[w] pulses for exactly cycle k+1. There is no grant and no bus_valid, and state stays IDLE.
  - rr_ptr = (w+1) mod NUM_REQ.
- XFER:
  - bus_sel and grant are held stable. Each edge decrements count.
  - The cycle in which count == 0 is the last transfer cycle; done[w] is high in that cycle.
  - The next edge returns to IDLE: bus_sel = IDLE_SEL, bus_valid = 0, grant = 0, rr_ptr = (w+1) mod NUM_REQ.
  - At least one IDLE cycle always separates transfers; back-to-back grants are not supported.
- Request changes during a transfer:
  - Changes to req, req_src or req_len while in XFER are ignored until IDLE.
  - If the owner drops req mid-transfer, the transfer still runs to completion.
- Latency: request sampled in IDLE to bus_valid high = 1 cycle. Total bus occupancy = len+1 cycles.
- Fairness: a continuously requesting requester waits at most (NUM_REQ-1) × (8+1) cycles plus one arbitration cycle.
- Invariants: at most one bit set in grant | err; done implies the matching grant bit; bus_valid == |grant.

Decomposition:
- Shared package holds:
  - the source-code constants SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_CSIGN, SRC_IDLE = 31;
  - the state enum {IDLE, XFER}.
- One sub-module is natural: rr_pick.
  - Purely combinational: a rotate, priority-find and rotate-back over req given rr_ptr.
  - Outputs a winner index and a valid flag.

Test Plan:
- Reset: hold clear low with req all high → bus_sel = 31 and grant/done/err/bus_valid = 0. Release clear → first grant goes to requester 0 one cycle later.
- Single transfer: only req[2] high, src = 20 (PC), len = 2 → bus_sel = 20 and grant = 0100 for exactly 3 cycles. done[2] is high in the 3rd cycle, then bus_sel = 31.
- Round-robin: req = 1111 held, all len = 0, src = i → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 1 cycle, separated by 1 idle cycle.
- Illegal code: req[1] high with src = 25, req[3] high with src = 5 → err[1] pulses one cycle with no bus_valid. The next arbitration grants requester 3 with bus_sel = 5.
- Mid-transfer events: during a len = 7 transfer of requester 0, change req_src[0] and drop req[0] → bus_sel stays constant for all 8 cycles and done[0] fires once.
- Reset mid-operation: assert clear in the 4th cycle of a len = 7 transfer → outputs return to reset values asynchronously with no done. After release, arbitration restarts from requester 0.
